// File: rtl/shift_ext_pkg.sv
// Op codes, op/state enums and FSM state constants shared by shift_ext_seq and shift_step.
package shift_ext_pkg;

   localparam logic [2:0] OPC_SLL      = 3'b000;
   localparam logic [2:0] OPC_SRL      = 3'b001;
   localparam logic [2:0] OPC_SRA      = 3'b010;
   localparam logic [2:0] OPC_SEXT     = 3'b011;
   localparam logic [2:0] OPC_ZEXT     = 3'b100;
   localparam logic [2:0] OPC_SEXT_SL2 = 3'b101;
   localparam logic [2:0] OPC_ROTL     = 3'b110;
   localparam logic [2:0] OPC_ROTR     = 3'b111;

   typedef enum logic [2:0] {
      OP_SLL      = OPC_SLL,
      OP_SRL      = OPC_SRL,
      OP_SRA      = OPC_SRA,
      OP_SEXT     = OPC_SEXT,
      OP_ZEXT     = OPC_ZEXT,
      OP_SEXT_SL2 = OPC_SEXT_SL2,
      OP_ROTL     = OPC_ROTL,
      OP_ROTR     = OPC_ROTR
   } op_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT,
      DONE  = ST_DONE
   } state_t;

endpackage

// File: rtl/shift_ext_seq_step.sv
// shift_step: combinational single-step shifter, moves "in" by amt (<= STEP) positions per op.
// Rotates exist only when SHIFT_EXT_ROTATE_EN is defined; any other op passes "in" through.
module shift_step
   import shift_ext_pkg::*;
#(
   parameter int N    = 32,
   parameter int STEP = 1
) (
   input  logic [N-1:0]               in,
   input  logic [$clog2(STEP+1)-1:0]  amt,
   input  logic [2:0]                 op,
   output logic [N-1:0]               out
);

   always_comb begin
      out = in;
      case (op)
         OPC_SLL: out = in << amt;
         OPC_SRL: out = in >> amt;
         OPC_SRA: out = N'($signed(in) >>> amt);
`ifdef SHIFT_EXT_ROTATE_EN
         // amt never reaches N, so the wrap term is 0 when amt is 0
         OPC_ROTL: out = (in << amt) | (in >> (N - int'(amt)));
         OPC_ROTR: out = (in >> amt) | (in << (N - int'(amt)));
`endif
         default: out = in;
      endcase
   end

endmodule

// File: rtl/shift_ext_seq.sv
// shift_ext_seq: multi-cycle shifter/immediate extender; extends and shamt=0 finish 1 cycle after start,
// shifts take ceil(shamt/STEP)+1 cycles; start is ignored while busy. Macro SHIFT_EXT_ROTATE_EN enables ROTL/ROTR.
module shift_ext_seq
   import shift_ext_pkg::*;
#(
   parameter int N     = 32,
   parameter int IMM_W = 16,
   parameter int STEP  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [N-1:0]          a,
   input  logic [$clog2(N)-1:0]  shamt,
   output logic                  busy,
   output logic                  done,
   output logic [N-1:0]          y,
   output logic                  illegal
);

   localparam int SW = $clog2(N);
   localparam int AW = $clog2(STEP+1);

   logic [1:0]    state;
   logic [2:0]    op_q;
   logic [N-1:0]  acc;
   logic [SW-1:0] rem;
   logic [AW-1:0] amt;
   logic [N-1:0]  step_out;
   logic [N-1:0]  imm_res;
   logic [N-1:0]  sext;
   logic          is_shift;
   logic          is_legal;

   assign sext = {{(N-IMM_W){a[IMM_W-1]}}, a[IMM_W-1:0]};

   // Result for every op that completes straight from IDLE (shifts here only when shamt is 0)
   always_comb begin
      is_shift = 1'b0;
      is_legal = 1'b1;
      imm_res  = '0;
      case (op)
         OPC_SLL, OPC_SRL, OPC_SRA: begin
            is_shift = 1'b1;
            imm_res  = a;
         end
         OPC_SEXT:     imm_res = sext;
         OPC_ZEXT:     imm_res = {{(N-IMM_W){1'b0}}, a[IMM_W-1:0]};
         OPC_SEXT_SL2: imm_res = sext << 2;
`ifdef SHIFT_EXT_ROTATE_EN
         OPC_ROTL, OPC_ROTR: begin
            is_shift = 1'b1;
            imm_res  = a;
         end
`endif
         default:      is_legal = 1'b0;
      endcase
   end

   assign amt = (rem > SW'(STEP)) ? AW'(STEP) : AW'(rem);

   shift_step #(.N(N), .STEP(STEP)) u_step (
      .in  (acc),
      .amt (amt),
      .op  (op_q),
      .out (step_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         op_q    <= OPC_SLL;
         acc     <= '0;
         rem     <= '0;
         y       <= '0;
         illegal <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op_q <= op;
                  acc  <= a;
                  rem  <= shamt;
                  if (is_shift && shamt != '0) begin
                     state <= ST_SHIFT;
                  end else begin
                     state   <= ST_DONE;
                     y       <= imm_res;
                     illegal <= ~is_legal;
                  end
               end
            end
            ST_SHIFT: begin
               acc <= step_out;
               rem <= rem - SW'(amt);
               if (rem == SW'(amt)) begin
                  state <= ST_DONE;
                  y     <= step_out;
               end
            end
            ST_DONE: begin
               state   <= ST_IDLE;
               illegal <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_shift_ext_seq.sv
// Directed plus random bench for shift_ext_seq (STEP=2) against an arithmetic reference model.
module tb_shift_ext_seq;

   localparam int N     = 32;
   localparam int IMM_W = 16;
   localparam int STEP  = 2;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [2:0]    op    = 3'd0;
   logic [N-1:0]  a     = '0;
   logic [4:0]    shamt = 5'd0;
   logic          busy;
   logic          done;
   logic [N-1:0]  y;
   logic          illegal;

   int checks   = 0;
   int failures = 0;

   shift_ext_seq #(.N(N), .IMM_W(IMM_W), .STEP(STEP)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .a       (a),
      .shamt   (shamt),
      .busy    (busy),
      .done    (done),
      .y       (y),
      .illegal (illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   // Reference: results from plain integer arithmetic (multiply/divide by powers of two)
   function automatic void model(input logic [2:0] o, input logic [31:0] av, input logic [4:0] sh,
                                 output logic [31:0] ey, output logic eill, output int elat);
      longint x, p, w, sv, q, v;
      x    = longint'(av);
      p    = longint'(1) << sh;
      w    = longint'(1) << 32;
      eill = 1'b0;
      ey   = '0;
      elat = (sh == 0) ? 1 : (int'(sh) + STEP - 1) / STEP + 1;
      v    = (av[15]) ? (x % 65536) - 65536 : (x % 65536);
      case (o)
         3'd0: ey = 32'(x * p);
         3'd1: ey = 32'(x / p);
         3'd2: begin
            sv = av[31] ? x - w : x;
            q  = (sv < 0) ? -((-sv + p - 1) / p) : sv / p;
            ey = 32'(q);
         end
         3'd3: begin ey = 32'(v);        elat = 1; end
         3'd4: begin ey = 32'(x % 65536); elat = 1; end
         3'd5: begin ey = 32'(v * 4);    elat = 1; end
`ifdef SHIFT_EXT_ROTATE_EN
         3'd6: ey = 32'(x * p + x / (w / p));
         3'd7: ey = 32'(x / p + x * (w / p));
`endif
         default: begin ey = '0; eill = 1'b1; elat = 1; end
      endcase
   endfunction

   task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [4:0] sh, input bit noise);
      logic [31:0] ey;
      logic        eill;
      int          elat;
      int          cyc;
      model(o, av, sh, ey, eill, elat);
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      start = 1'b1; op = o; a = av; shamt = sh;
      @(negedge clk);
      start = 1'b0; op = 3'($urandom); a = $urandom; shamt = 5'($urandom);
      cyc = 1;
      while (done !== 1'b1 && cyc < 64) begin
         check("busy_run", 32'(busy), 32'd1);
         check("illegal_run", 32'(illegal), 32'd0);
         if (noise) begin
            start = 1'($urandom); op = 3'($urandom); a = $urandom; shamt = 5'($urandom);
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check("latency", 32'(cyc), 32'(elat));
      check("busy_done", 32'(busy), 32'd1);
      check("y", y, ey);
      check("illegal", 32'(illegal), 32'(eill));
      @(negedge clk);
      check("done_clr", 32'(done), 32'd0);
      check("busy_clr", 32'(busy), 32'd0);
      check("illegal_clr", 32'(illegal), 32'd0);
      check("y_hold", y, ey);
   endtask

   initial begin
      int seen;
      #1;
      check("rst_y", y, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      run_op(3'd0, 32'h0000_0001, 5'd31, 1'b0);
      check("sll31_y", y, 32'h8000_0000);
      run_op(3'd2, 32'h8000_0000, 5'd4, 1'b0);
      check("sra4_y", y, 32'hF800_0000);
      run_op(3'd1, 32'h8000_0000, 5'd4, 1'b0);
      check("srl4_y", y, 32'h0800_0000);
      run_op(3'd5, 32'h0000_8001, 5'd7, 1'b0);
      check("sext_sl2_y", y, 32'hFFFE_0004);
      run_op(3'd4, 32'h0000_8001, 5'd0, 1'b0);
      check("zext_y", y, 32'h0000_8001);
      run_op(3'd3, 32'h1234_8001, 5'd3, 1'b0);
      run_op(3'd0, 32'hDEAD_BEEF, 5'd0, 1'b0);
      run_op(3'd2, 32'h8765_4321, 5'd5, 1'b0);
      run_op(3'd1, 32'hCAFE_F00D, 5'd9, 1'b1);
      run_op(3'd6, 32'h8000_0001, 5'd1, 1'b0);
`ifdef SHIFT_EXT_ROTATE_EN
      check("rotl1_y", y, 32'h0000_0003);
`else
      check("op6_illegal_y", y, 32'h0000_0000);
`endif
      run_op(3'd7, 32'h8000_0001, 5'd1, 1'b0);

      // Abort a shift with reset three cycles in
      run_op(3'd4, 32'h0000_ABCD, 5'd0, 1'b0);
      @(negedge clk);
      start = 1'b1; op = 3'd0; a = 32'h0000_FFFF; shamt = 5'd20;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_y", y, 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_illegal", 32'(illegal), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      check("no_done_after_abort", 32'(seen), 32'd0);
      run_op(3'd0, 32'h0000_0003, 5'd6, 1'b0);
      check("after_abort_y", y, 32'h0000_00C0);

      for (int i = 0; i < 40; i++) begin
         run_op(3'($urandom), $urandom, 5'($urandom), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
